// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one uart_tx serializer among NUM_REQ
// byte-stream requesters, with a per-grant stall timeout.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int LOCK_TIMEOUT = 1000
) (
   input  logic                 i_Clock,
   input  logic                 i_Rst_L,
   input  logic [NUM_REQ-1:0]   i_Req_Valid,
   input  logic [8*NUM_REQ-1:0] i_Req_Data,
   input  logic [NUM_REQ-1:0]   i_Req_Last,
   output logic [NUM_REQ-1:0]   o_Req_Ready,
   output logic [NUM_REQ-1:0]   o_Grant,
   output logic [NUM_REQ-1:0]   o_Abort,
   output logic                 o_Busy,
   output logic                 o_Tx_DV,
   output logic [7:0]           o_Tx_Byte,
   input  logic                 i_Tx_Active,
   input  logic                 i_Tx_Done
);

   localparam int IDXW = $clog2(NUM_REQ);
   localparam int CNTW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_DONE,
      WAIT_IDLE
   } state_t;

   state_t            state, state_next;
   logic [IDXW-1:0]   owner, owner_next;
   logic [IDXW-1:0]   last_served, last_served_next;
   logic [IDXW-1:0]   pick, cand;
   logic              pick_found;
   logic [CNTW-1:0]   timeout_cnt, timeout_cnt_next, cnt_inc;
   logic              timeout_hit;
   logic              last_flag, last_flag_next;
   logic [NUM_REQ-1:0] grant_next, abort_next;
   logic              tx_dv_next;
   logic [7:0]        tx_byte_next;
   logic              accept;
   logic [7:0]        req_byte [NUM_REQ];

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
      assign req_byte[k] = i_Req_Data[8*k +: 8];
   end

   // First valid requester after the last one served, wrapping around.
   always_comb begin
      pick       = '0;
      pick_found = 1'b0;
      cand       = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = IDXW'((int'(last_served) + i) % NUM_REQ);
         if (!pick_found && i_Req_Valid[cand]) begin
            pick       = cand;
            pick_found = 1'b1;
         end
      end
   end

   assign accept      = (state == ISSUE) && i_Req_Valid[owner];
   assign cnt_inc     = (timeout_cnt == {CNTW{1'b1}}) ? timeout_cnt : timeout_cnt + CNTW'(1);
   assign timeout_hit = (LOCK_TIMEOUT != 0) && (cnt_inc == CNTW'(LOCK_TIMEOUT));
   assign o_Busy      = (state != IDLE);

   always_comb begin
      o_Req_Ready = '0;
      if (state == ISSUE) begin
         o_Req_Ready[owner] = i_Req_Valid[owner];
      end
   end

   always_comb begin
      state_next       = state;
      owner_next       = owner;
      last_served_next = last_served;
      timeout_cnt_next = timeout_cnt;
      last_flag_next   = last_flag;
      grant_next       = o_Grant;
      abort_next       = '0;
      tx_dv_next       = 1'b0;
      tx_byte_next     = o_Tx_Byte;
      case (state)
         IDLE: begin
            if (pick_found) begin
               owner_next       = pick;
               grant_next       = NUM_REQ'(1) << pick;
               timeout_cnt_next = '0;
               state_next       = ISSUE;
            end
         end
         ISSUE: begin
            if (accept) begin
               tx_byte_next     = req_byte[owner];
               tx_dv_next       = 1'b1;
               last_flag_next   = i_Req_Last[owner];
               timeout_cnt_next = '0;
               state_next       = WAIT_DONE;
            end else begin
               timeout_cnt_next = cnt_inc;
               if (timeout_hit) begin
                  abort_next       = NUM_REQ'(1) << owner;
                  grant_next       = '0;
                  last_served_next = owner;
                  timeout_cnt_next = '0;
                  state_next       = IDLE;
               end
            end
         end
         WAIT_DONE: begin
            if (i_Tx_Done) begin
               state_next = WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            // Done may be held for several cycles; only move on once the serializer is fully idle.
            if (!i_Tx_Done && !i_Tx_Active) begin
               if (last_flag) begin
                  last_served_next = owner;
                  grant_next       = '0;
                  state_next       = IDLE;
               end else begin
                  state_next = ISSUE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state       <= IDLE;
         owner       <= '0;
         last_served <= IDXW'(NUM_REQ - 1);
         timeout_cnt <= '0;
         last_flag   <= 1'b0;
         o_Grant     <= '0;
         o_Abort     <= '0;
         o_Tx_DV     <= 1'b0;
         o_Tx_Byte   <= 8'h00;
      end else begin
         state       <= state_next;
         owner       <= owner_next;
         last_served <= last_served_next;
         timeout_cnt <= timeout_cnt_next;
         last_flag   <= last_flag_next;
         o_Grant     <= grant_next;
         o_Abort     <= abort_next;
         o_Tx_DV     <= tx_dv_next;
         o_Tx_Byte   <= tx_byte_next;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, a uart_tx timing model and a
// packet-level round-robin scoreboard.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ      = 4;
   localparam int LOCK_TIMEOUT = 16;
   localparam int DEPTH        = 64;

   logic                 clock = 1'b0;
   logic                 rst_l;
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic [NUM_REQ-1:0]   grant;
   logic [NUM_REQ-1:0]   abort;
   logic                 busy;
   logic                 tx_dv;
   logic [7:0]           tx_byte;
   logic                 tx_active;
   logic                 tx_done;

   uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .LOCK_TIMEOUT(LOCK_TIMEOUT)) dut (
      .i_Clock     (clock),
      .i_Rst_L     (rst_l),
      .i_Req_Valid (req_valid),
      .i_Req_Data  (req_data),
      .i_Req_Last  (req_last),
      .o_Req_Ready (req_ready),
      .o_Grant     (grant),
      .o_Abort     (abort),
      .o_Busy      (busy),
      .o_Tx_DV     (tx_dv),
      .o_Tx_Byte   (tx_byte),
      .i_Tx_Active (tx_active),
      .i_Tx_Done   (tx_done)
   );

   always #5 clock = ~clock;

   logic [8:0] req_mem [NUM_REQ][DEPTH];
   int         head [NUM_REQ];
   int         tail [NUM_REQ];
   logic [7:0] exp_byte [$];
   int         exp_req [$];

   int         checks, errors, cyc, dv_count, idle_cyc, base;
   logic       obs_dv, obs_busy;
   logic [7:0] obs_byte;
   logic [NUM_REQ-1:0] obs_grant, obs_abort, obs_ready;
   bit         abort_allowed, rand_tx, tx_start, found;
   int         tx_len, tx_done_len, tx_act_left, tx_done_left;
   int         model_ls;

   task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, want);
      end
   endtask

   task automatic apply_stimulus();
      for (int k = 0; k < NUM_REQ; k++) begin
         if (head[k] < tail[k]) begin
            req_valid[k]      = 1'b1;
            req_data[8*k +: 8] = req_mem[k][head[k]][7:0];
            req_last[k]       = req_mem[k][head[k]][8];
         end else begin
            req_valid[k]      = 1'b0;
            req_data[8*k +: 8] = 8'h00;
            req_last[k]       = 1'b0;
         end
      end
   endtask

   task automatic push(input int k, input logic [7:0] b, input logic last);
      req_mem[k][tail[k]] = {last, b};
      tail[k]++;
      apply_stimulus();
   endtask

   task automatic expect_dv(input int k, input logic [7:0] b);
      exp_req.push_back(k);
      exp_byte.push_back(b);
   endtask

   // One clock: observe at the falling edge, then update requesters and the tx model after the rising edge.
   task automatic run_cycle();
      logic [NUM_REQ-1:0] adv;
      logic [7:0]         eb;
      int                 er;
      @(negedge clock);
      cyc++;
      obs_dv    = tx_dv;
      obs_byte  = tx_byte;
      obs_grant = grant;
      obs_abort = abort;
      obs_ready = req_ready;
      obs_busy  = busy;
      adv       = req_valid & req_ready;
      check_output("ready_owner", 32'(req_ready & ~(req_valid & grant)), 32'd0);
      check_output("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
      if (!abort_allowed) check_output("no_abort", 32'(abort), 32'd0);
      if (tx_dv) begin
         dv_count++;
         check_output("dv_while_tx_busy", 32'(tx_active | tx_done | tx_start), 32'd0);
         tx_start = 1'b1;
         check_output("dv_expected", 32'(exp_byte.size() > 0), 32'd1);
         if (exp_byte.size() > 0) begin
            eb = exp_byte.pop_front();
            er = exp_req.pop_front();
            check_output("tx_byte", 32'(tx_byte), 32'(eb));
            check_output("dv_grant", 32'(grant), 32'(1 << er));
         end
      end
      @(posedge clock);
      #1;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (adv[k]) head[k]++;
      end
      if (tx_start) begin
         tx_start    = 1'b0;
         tx_active   = 1'b1;
         tx_act_left = rand_tx ? int'($urandom_range(6, 1)) : tx_len;
      end else if (tx_act_left > 0) begin
         tx_act_left--;
         if (tx_act_left == 0) begin
            tx_active    = 1'b0;
            tx_done      = 1'b1;
            tx_done_left = rand_tx ? int'($urandom_range(3, 1)) : tx_done_len;
         end
      end else if (tx_done_left > 0) begin
         tx_done_left--;
         if (tx_done_left == 0) begin
            tx_done  = 1'b0;
            idle_cyc = cyc;
         end
      end
      apply_stimulus();
   endtask

   function automatic bit all_idle();
      bit r;
      r = !obs_busy && !tx_active && !tx_done && !tx_start && (exp_byte.size() == 0);
      for (int k = 0; k < NUM_REQ; k++) begin
         if (head[k] != tail[k]) r = 1'b0;
      end
      return r;
   endfunction

   task automatic wait_dv(input int n, input int budget);
      for (int i = 0; i < budget && dv_count < n; i++) run_cycle();
      check_output("dv_wait", 32'(dv_count >= n), 32'd1);
   endtask

   task automatic wait_idle(input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         run_cycle();
         ok = all_idle();
      end
      check_output("idle_wait", 32'(ok), 32'd1);
   endtask

   task automatic reset_dut();
      rst_l = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         head[k] = 0;
         tail[k] = 0;
      end
      exp_byte.delete();
      exp_req.delete();
      tx_active    = 1'b0;
      tx_done      = 1'b0;
      tx_start     = 1'b0;
      tx_act_left  = 0;
      tx_done_left = 0;
      apply_stimulus();
      repeat (2) @(posedge clock);
      @(negedge clock);
      check_output("reset_grant", 32'(grant), 32'd0);
      check_output("reset_ready", 32'(req_ready), 32'd0);
      check_output("reset_abort", 32'(abort), 32'd0);
      check_output("reset_busy", 32'(busy), 32'd0);
      check_output("reset_dv", 32'(tx_dv), 32'd0);
      check_output("reset_byte", 32'(tx_byte), 32'd0);
      rst_l = 1'b1;
      @(posedge clock);
      #1;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [7:0] b;
      int         order [6];
      int         ptr [NUM_REQ];
      int         total, c, sel, npk, len;
      checks = 0; errors = 0; cyc = 0; dv_count = 0; idle_cyc = 0;
      abort_allowed = 1'b0; rand_tx = 1'b0;
      tx_len = 3; tx_done_len = 1;
      req_valid = '0; req_data = '0; req_last = '0;
      reset_dut();

      $display("[TB] single byte");
      base = dv_count;
      push(2, 8'hA5, 1'b1);
      expect_dv(2, 8'hA5);
      run_cycle();
      check_output("t1_grant_c0", 32'(obs_grant), 32'd0);
      check_output("t1_busy_c0", 32'(obs_busy), 32'd0);
      run_cycle();
      check_output("t1_grant_c1", 32'(obs_grant), 32'b0100);
      check_output("t1_ready_c1", 32'(obs_ready), 32'b0100);
      check_output("t1_dv_c1", 32'(obs_dv), 32'd0);
      run_cycle();
      check_output("t1_dv_c2", 32'(obs_dv), 32'd1);
      check_output("t1_byte_c2", 32'(obs_byte), 32'hA5);
      wait_idle(100);
      check_output("t1_grant_end", 32'(obs_grant), 32'd0);
      check_output("t1_busy_end", 32'(obs_busy), 32'd0);
      check_output("t1_byte_held", 32'(obs_byte), 32'hA5);
      check_output("t1_dv_count", 32'(dv_count - base), 32'd1);

      $display("[TB] packet lock with done held high");
      tx_done_len = 2;
      base = dv_count;
      push(0, 8'h11, 1'b0);
      push(0, 8'h22, 1'b0);
      push(0, 8'h33, 1'b1);
      push(1, 8'h44, 1'b1);
      expect_dv(0, 8'h11);
      expect_dv(0, 8'h22);
      expect_dv(0, 8'h33);
      expect_dv(1, 8'h44);
      wait_dv(base + 4, 300);
      wait_idle(100);
      check_output("t2_dv_count", 32'(dv_count - base), 32'd4);

      $display("[TB] round robin");
      tx_done_len = 1;
      reset_dut();
      base = dv_count;
      order = '{0, 1, 2, 3, 0, 1};
      for (int i = 0; i < 6; i++) begin
         b = 8'($urandom);
         push(order[i], b, 1'b1);
         expect_dv(order[i], b);
      end
      wait_dv(base + 6, 400);
      wait_idle(100);
      check_output("t3_dv_count", 32'(dv_count - base), 32'd6);

      $display("[TB] lock timeout");
      reset_dut();
      abort_allowed = 1'b1;
      base = dv_count;
      push(3, 8'h5A, 1'b0);
      expect_dv(3, 8'h5A);
      wait_dv(base + 1, 50);
      push(0, 8'hC3, 1'b1);
      expect_dv(0, 8'hC3);
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         run_cycle();
         if (obs_abort != '0) found = 1'b1;
      end
      check_output("t5_abort_seen", 32'(found), 32'd1);
      check_output("t5_abort", 32'(obs_abort), 32'b1000);
      check_output("t5_grant_at_abort", 32'(obs_grant), 32'd0);
      check_output("t5_abort_delay", 32'(cyc - idle_cyc), 32'd18);
      run_cycle();
      check_output("t5_abort_pulse", 32'(obs_abort), 32'd0);
      abort_allowed = 1'b0;
      wait_dv(base + 2, 50);
      wait_idle(100);

      $display("[TB] reset mid-packet");
      reset_dut();
      base = dv_count;
      push(1, 8'h77, 1'b0);
      push(1, 8'h88, 1'b1);
      expect_dv(1, 8'h77);
      wait_dv(base + 1, 50);
      #2;
      check_output("t6_busy_before", 32'(busy), 32'd1);
      rst_l = 1'b0;
      #1;
      check_output("t6_grant", 32'(grant), 32'd0);
      check_output("t6_busy", 32'(busy), 32'd0);
      check_output("t6_dv", 32'(tx_dv), 32'd0);
      check_output("t6_byte", 32'(tx_byte), 32'd0);
      check_output("t6_abort", 32'(abort), 32'd0);
      check_output("t6_ready", 32'(req_ready), 32'd0);
      reset_dut();
      base = dv_count;
      push(3, 8'h3C, 1'b1);
      push(0, 8'hC0, 1'b1);
      expect_dv(0, 8'hC0);
      expect_dv(3, 8'h3C);
      wait_dv(base + 2, 100);
      wait_idle(100);

      $display("[TB] randomized packets");
      reset_dut();
      rand_tx  = 1'b1;
      model_ls = NUM_REQ - 1;
      for (int round = 0; round < 4; round++) begin
         base  = dv_count;
         total = 0;
         for (int k = 0; k < NUM_REQ; k++) begin
            ptr[k] = tail[k];
            npk = int'($urandom_range(3, 0));
            for (int p = 0; p < npk; p++) begin
               len = int'($urandom_range(3, 1));
               for (int j = 0; j < len; j++) begin
                  req_mem[k][tail[k]] = {(j == len - 1), 8'($urandom)};
                  tail[k]++;
               end
            end
         end
         // Whole packets, granted round robin among requesters that still hold data.
         forever begin
            sel = -1;
            for (int i = 1; i <= NUM_REQ && sel < 0; i++) begin
               c = (model_ls + i) % NUM_REQ;
               if (ptr[c] < tail[c]) sel = c;
            end
            if (sel < 0) break;
            forever begin
               expect_dv(sel, req_mem[sel][ptr[sel]][7:0]);
               total++;
               ptr[sel]++;
               if (req_mem[sel][ptr[sel] - 1][8]) break;
            end
            model_ls = sel;
         end
         apply_stimulus();
         wait_dv(base + total, 3000);
         wait_idle(200);
         check_output("rand_dv_count", 32'(dv_count - base), 32'(total));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-locked round-robin arbiter that shares one `uart_tx` serializer among `NUM_REQ` byte-stream requesters. It sits between the requesters and the transmitter. It grants one requester at a time, holds the grant until that requester's last byte of a packet has been sent, and issues exactly one `i_Tx_DV` pulse per byte. It sequences each byte on the transmitter's done/active status, and a lock timeout releases a requester that stalls mid-packet.

## Interface

Parameters:
- `NUM_REQ`, default 4. Number of requesters; legal range 2..8.
- `LOCK_TIMEOUT`, default 1000. Number of cycles a granted requester may hold `i_Req_Valid` low mid-packet before its lock is dropped. A value of 0 disables the timeout.

Ports:
- `i_Clock` (in, 1): system clock. One clock domain; all logic is on the rising edge.
- `i_Rst_L` (in, 1): asynchronous, active-low reset.
- `i_Req_Valid` (in, NUM_REQ): per-requester byte valid.
- `i_Req_Data` (in, 8*NUM_REQ): per-requester byte. Requester k uses bits [8k+7:8k].
- `i_Req_Last` (in, NUM_REQ): marks the last byte of a packet; qualified by valid.
- `o_Req_Ready` (out, NUM_REQ): combinational, one-hot. A byte is accepted when valid and ready are both high in the same cycle.
- `o_Grant` (out, NUM_REQ): registered, one-hot. Shows the current packet owner.
- `o_Abort` (out, NUM_REQ): registered. One-cycle pulse on the requester whose lock timed out.
- `o_Busy` (out, 1): high whenever the state is not IDLE.
- `o_Tx_DV` (out, 1): to the transmitter's `i_Tx_DV`. One-cycle pulse.
- `o_Tx_Byte` (out, 8): to the transmitter's `i_Tx_Byte`. Valid while `o_Tx_DV` is high and held afterwards.
- `i_Tx_Active` (in, 1): from the transmitter's `o_Tx_Active`.
- `i_Tx_Done` (in, 1): from the transmitter's `o_Tx_Done`. May stay high for more than one cycle.

## Operation

Reset values:
- `o_Req_Ready`, `o_Grant`, `o_Abort`, `o_Tx_DV`, `o_Busy` = 0.
- `o_Tx_Byte` = 8'h00.
- State = IDLE; owner = 0; last-served pointer = NUM_REQ-1, so requester 0 has first priority.
- Timeout counter = 0; last-byte flag = 0.

State machine:
- **IDLE**
  - If any `i_Req_Valid` bit is set, select the first valid requester searching upward from (last-served+1), wrapping modulo NUM_REQ.
  - Register it as owner, set `o_Grant` one-hot, go to ISSUE.
  - If no request is valid, stay in IDLE.
- **ISSUE**
  - `o_Req_Ready[owner] = i_Req_Valid[owner]`; all other ready bits are 0.
  - On accept:
    - Register `o_Tx_Byte` = owner's data and pulse `o_Tx_DV` = 1 for the next cycle.
    - Latch last-byte flag = `i_Req_Last[owner]`.
    - Clear the timeout counter and go to WAIT_DONE.
  - If not valid, increment the timeout counter. When it reaches LOCK_TIMEOUT (and LOCK_TIMEOUT != 0):
    - Pulse `o_Abort[owner]` and clear `o_Grant`.
    - Set last-served = owner and go to IDLE.
- **WAIT_DONE**: wait for `i_Tx_Done` = 1.
- **WAIT_IDLE**: wait for `i_Tx_Done` = 0 and `i_Tx_Active` = 0. This guarantees the transmitter has returned to idle before the next DV.
  - If the last-byte flag is set: set last-served = owner, clear `o_Grant`, go to IDLE.
  - Otherwise go back to ISSUE with the same owner.

Rules:
- A grant is never preempted by another requester. Only last-byte completion, the timeout, or reset ends it.
- Data from requesters that are not the owner is never sampled.
- A requester must hold data and last stable while valid is high until it sees ready.
- Arithmetic:
  - Timeout counter width is clog2(LOCK_TIMEOUT+1) bits and saturates; it never wraps.
  - The round-robin index is computed modulo NUM_REQ.
- Reset asserted mid-operation forces all reset values immediately. The packet is abandoned and no `o_Abort` pulse is issued.
- Valid arriving in the same cycle as the grant release is arbitrated in the following IDLE cycle. The requester just released has the lowest priority there.

## Timing

- **Request to DV**: valid arrives in IDLE at cycle 0 → ISSUE at cycle 1, with ready high (combinational) → `o_Tx_DV` high at cycle 2. Latency is 2 cycles.
- **Pulse width**: `o_Tx_DV` is high for exactly one cycle per accepted byte, never more than one per `i_Tx_Done` cycle.
- **Byte to byte within a packet**: WAIT_IDLE exits 1 cycle after `i_Tx_Done` falls (with `i_Tx_Active` low) → ISSUE → DV on the next cycle.
- **Grant lifetime**: `o_Grant` rises 1 cycle after IDLE arbitration. It falls on the cycle the state enters IDLE.
- **Abort**: `o_Abort` coincides with `o_Grant` falling.

## Test plan

- **Single byte**: NUM_REQ=4; requester 2 sends 8'hA5 with last=1 → one `o_Tx_DV` pulse with `o_Tx_Byte`=8'hA5 at cycle 2; `o_Grant`=4'b0100 until done clears; `o_Busy` low after.
- **Packet lock**: requester 0 sends a 3-byte packet (8'h11, 8'h22, 8'h33) while requester 1 is valid throughout → DV sequence is 11, 22, 33, then requester 1's byte; requester 1 sees no ready until requester 0's last byte completes.
- **Round robin**: all 4 requesters continuously valid with single-byte packets → grant order 0, 1, 2, 3, 0, 1.
- **Done held high**: the bench holds `i_Tx_Done` high for 2 cycles → exactly one DV per byte; the next DV comes only after done is low and active is low.
- **Timeout**: LOCK_TIMEOUT=16; requester 3 sends a non-last byte, then drops valid → after 16 ISSUE cycles `o_Abort`=4'b1000 for 1 cycle, the grant is released, and waiting requester 0 is granted.
- **Reset mid-packet**: assert `i_Rst_L`=0 in WAIT_DONE → all outputs 0 asynchronously; after release, requester 0 has priority and no abort pulse is issued.
